// File: rtl/fifo_state_dp.sv
// rtl/fifo_state_dp.sv - FIFO state register, pointers, occupancy, storage and status flags
// Optional registered almost_full/almost_empty flags enabled by macro FIFO_ALMOST_FLAG_EN.
module fifo_state_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            next_state,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [2:0]            state,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_NO_OP    = 3'b001,
    ST_WRITE    = 3'b010,
    ST_WR_ERROR = 3'b011,
    ST_READ     = 3'b100,
    ST_RD_ERROR = 3'b101
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
  logic                    rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
  logic                    do_write;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  always_comb begin
    state_d  = state_t'(next_state);
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    dout_d   = dout_q;
    wr_ack_d = 1'b0;
    wr_err_d = 1'b0;
    rd_ack_d = 1'b0;
    rd_err_d = 1'b0;
    do_write = 1'b0;
    case (next_state)
      ST_INIT: begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        dout_d  = '0;
      end
      ST_NO_OP: ;
      ST_WRITE: begin
        // A write into a full FIFO is rejected here even if the decoder let it through.
        if (full) begin
          wr_err_d = 1'b1;
        end else begin
          do_write = 1'b1;
          tail_d   = tail_q + ADDR_WIDTH'(1);
          count_d  = count_q + (ADDR_WIDTH + 1)'(1);
          wr_ack_d = 1'b1;
        end
      end
      ST_WR_ERROR: wr_err_d = 1'b1;
      ST_READ: begin
        if (empty) begin
          rd_err_d = 1'b1;
        end else begin
          dout_d   = mem[head_q];
          head_d   = head_q + ADDR_WIDTH'(1);
          count_d  = count_q - (ADDR_WIDTH + 1)'(1);
          rd_ack_d = 1'b1;
        end
      end
      ST_RD_ERROR: rd_err_d = 1'b1;
      default: state_d = ST_NO_OP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_INIT;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Storage has no reset; gating on reset_n drops a write racing a reset assertion.
  always_ff @(posedge clk) begin
    if (reset_n && do_write) mem[tail_q] <= din;
  end

`ifdef FIFO_ALMOST_FLAG_EN
  logic almost_full_q, almost_empty_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b0;
    end else begin
      almost_full_q  <= (count_d >= FULL_COUNT - (ADDR_WIDTH + 1)'(1));
      almost_empty_q <= (count_d <= (ADDR_WIDTH + 1)'(1));
    end
  end
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

  assign state      = state_q;
  assign data_count = count_q;
  assign dout       = dout_q;
  assign wr_ack     = wr_ack_q;
  assign wr_err     = wr_err_q;
  assign rd_ack     = rd_ack_q;
  assign rd_err     = rd_err_q;

endmodule
